stopwatch_ctrl: RTL and testbench

Controller that sequences a chain of cascaded decade (BCD 0-9) digit counters as a start/stop/lap stopwatch. Generates the count-enable tick from a clock prescaler and ripples carries across digits. Runs a run/pause/idle FSM driven by single-cycle command pulses, and provides a lap-freeze display path. Sits between the debounced button pulses and the 7-segment/display driver.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_ctrl_decade_digit.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_t   : controller FSM state encoding (IDLE / RUN / PAUSE)
//   BCD_W     : width of one BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   bcd_next  : next value of a decade digit when it is enabled
package stopwatch_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Any value at or above 9 folds back to 0, so a digit can never leave 0..9.
    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        logic [3:0] r;
        if (d >= BCD_MAX) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_decade_digit.sv
// One BCD decade counter of the stopwatch chain.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable (tick rippled from lower digits)
//   clr      : synchronous clear to 0 (dominates en)
//   q        : current digit value 0..9
//   carry    : en & (q == 9), enables the next digit in the same cycle
module decade_digit
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] q_r;

    // Digit register: clear, advance on enable, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (en) begin
            q_r <= bcd_next(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q     = q_r;
    assign carry = en & (q_r == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch controller over a chain of decade digits.
//   clk, rst    : clock, asynchronous active-high reset
//   start_stop  : pulse, IDLE->RUN, RUN<->PAUSE
//   clear       : pulse, IDLE/PAUSE -> IDLE with everything zeroed (ignored in RUN)
//   lap         : pulse, in RUN toggles the frozen-display snapshot
//   disp        : displayed BCD value (snapshot while lap is active), digit 0 in [3:0]
//   running     : high in RUN
//   lap_active  : high while the display is frozen
//   overflow    : sticky, set when the count wraps from all-9s to all-0s
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_stop,
    input  logic                        clear,
    input  logic                        lap,
    output logic [BCD_W*NUM_DIGITS-1:0] disp,
    output logic                        running,
    output logic                        lap_active,
    output logic                        overflow
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE   = PW'(1);
    localparam int             DW        = BCD_W * NUM_DIGITS;

    state_t            state_r;
    state_t            next_state_s;
    logic [PW-1:0]     presc_r;
    logic [DW-1:0]     digits_s;
    logic [DW-1:0]     snapshot_r;
    logic              lap_r;
    logic              overflow_r;
    logic              tick_s;
    logic              clr_s;
    logic              in_run_s;
    logic              running_s;
    logic [DW-1:0]     disp_s;
    logic [NUM_DIGITS:0] en_s;

    assign in_run_s = (state_r == ST_RUN);
    // clear only acts outside RUN; it zeros every piece of state at once.
    assign clr_s    = clear & ~in_run_s;
    assign tick_s   = in_run_s & (presc_r == PRE_LAST);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; clear beats start_stop outside RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    next_state_s = ST_IDLE;
                end else if (start_stop) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_stop) begin
                    next_state_s = ST_PAUSE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    next_state_s = ST_IDLE;
                end else if (start_stop) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_PAUSE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs and display mux (combinational from registers, no added latency).
    always_comb begin
        running_s = 1'b0;
        disp_s    = digits_s;
        if (state_r == ST_RUN) begin
            running_s = 1'b1;
        end else begin
            running_s = 1'b0;
        end
        if (lap_r) begin
            disp_s = snapshot_r;
        end else begin
            disp_s = digits_s;
        end
    end

    // Prescaler: advances only in RUN, holds in PAUSE so a resume finishes the partial period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else if (clr_s) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else if (in_run_s) begin
            presc_r <= presc_r + PRE_ONE;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Lap snapshot captures the pre-increment count; overflow is sticky until clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot_r <= '0;
            lap_r      <= 1'b0;
            overflow_r <= 1'b0;
        end else if (clr_s) begin
            snapshot_r <= '0;
            lap_r      <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (in_run_s && lap && !lap_r) begin
                snapshot_r <= digits_s;
                lap_r      <= 1'b1;
            end else if (in_run_s && lap) begin
                lap_r      <= 1'b0;
            end else begin
                lap_r      <= lap_r;
            end
            // Carry out of the top digit means every digit was 9 on a tick.
            if (en_s[NUM_DIGITS]) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign en_s[0] = tick_s;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            decade_digit u_digit (
                .clk   (clk),
                .rst   (rst),
                .en    (en_s[g]),
                .clr   (clr_s),
                .q     (digits_s[g*BCD_W +: BCD_W]),
                .carry (en_s[g+1])
            );
        end
    endgenerate

    assign disp       = disp_s;
    assign running    = running_s;
    assign lap_active = lap_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int ND   = 2;
    localparam int TD   = 2;
    localparam int MAXV = 100;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_stop = 1'b0;
    logic            clear = 1'b0;
    logic            lap = 1'b0;
    logic [4*ND-1:0] disp;
    logic            running;
    logic            lap_active;
    logic            overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: count is a plain integer, prescale a plain cycle counter.
    int m_state, m_count, m_pre, m_snap, m_lap, m_ovf;

    stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4*ND-1:0] bcd(input int v);
        logic [4*ND-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4*ND-1:0] exp_disp();
        return (m_lap != 0) ? bcd(m_snap) : bcd(m_count);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_count = 0; m_pre = 0; m_snap = 0; m_lap = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic ss, input logic cl, input logic lp);
        bit tick;
        tick = (m_state == M_RUN) && (m_pre == TD - 1);
        if (m_state != M_RUN && cl) begin
            model_reset();
        end else if (m_state == M_RUN) begin
            if (lp) begin
                if (m_lap == 0) begin m_snap = m_count; m_lap = 1; end
                else m_lap = 0;
            end
            if (tick) begin
                m_pre = 0;
                if (m_count == MAXV - 1) begin m_count = 0; m_ovf = 1; end
                else m_count = m_count + 1;
            end else begin
                m_pre = m_pre + 1;
            end
            if (ss) m_state = M_PAUSE;
        end else if (ss) begin
            m_state = M_RUN;
        end
    endtask

    task automatic step(input logic ss, input logic cl, input logic lp);
        start_stop = ss; clear = cl; lap = lp;
        @(posedge clk);
        model_edge(ss, cl, lp);
        #1;
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic run_until(input int target, input int pre_want, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_count == target && (pre_want < 0 || m_pre == pre_want)) && n < budget) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (m_count != target || disp !== bcd(target)) begin
            errors++;
            $display("FAIL %s: disp=%h required=%h after %0d cycles", name, disp, bcd(target), n);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({disp, running, overflow, lap_active} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs: disp=%h run=%b ovf=%b lap=%b required 00/0/0/0", disp, running, overflow, lap_active);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1 || disp !== 8'h00) begin
            errors++;
            $display("FAIL start_after_reset: running=%b disp=%h required 1/00", running, disp);
        end
    endtask

    task automatic test_basic_count();
        repeat (40) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (disp !== 8'h20) begin
            errors++;
            $display("FAIL basic_count: disp=%h required=20", disp);
        end
    endtask

    task automatic test_pause_resume();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_until(14, 0, 100, "reach_14");
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (running !== 1'b1 || disp !== 8'h14) begin
            errors++;
            $display("FAIL clear_in_run: running=%b disp=%h required 1/14", running, disp);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (disp !== 8'h15 || running !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold: disp=%h running=%b required 15/0", disp, running);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (disp !== 8'h15 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume_edge: disp=%h running=%b required 15/1", disp, running);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (disp !== 8'h16) begin
            errors++;
            $display("FAIL resume_partial_prescale: disp=%h required=16", disp);
        end
    endtask

    task automatic test_wrap();
        run_until(99, TD - 1, 400, "reach_99");
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (disp !== 8'h00 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap: disp=%h overflow=%b required 00/1", disp, overflow);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b0 || running !== 1'b0 || disp !== 8'h00) begin
            errors++;
            $display("FAIL clear_after_wrap: overflow=%b running=%b disp=%h required 0/0/00", overflow, running, disp);
        end
    endtask

    task automatic test_lap();
        int n;
        step(1'b1, 1'b0, 1'b0);
        run_until(7, 0, 100, "reach_07");
        step(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!(m_count == 13 && m_pre == 0) && n < 100) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            checks++;
            if (disp !== 8'h07 || lap_active !== 1'b1) begin
                errors++;
                $display("FAIL lap_frozen: disp=%h lap_active=%b required 07/1", disp, lap_active);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp !== 8'h13 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL lap_release: disp=%h lap_active=%b required 13/0", disp, lap_active);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (lap_active !== 1'b0 || disp !== exp_disp()) begin
            errors++;
            $display("FAIL lap_in_pause: lap_active=%b disp=%h required 0/%h", lap_active, disp, exp_disp());
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_until(42, -1, 200, "reach_42");
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (disp !== 8'h00 || running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: disp=%h running=%b required 00/0", disp, running);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b0 || disp !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: running=%b disp=%h required 0/00", running, disp);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_reset: running=%b required 1", running);
        end
    endtask

    task automatic test_random();
        logic ss, cl, lp;
        for (int i = 0; i < 600; i++) begin
            ss = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 11) == 0);
            lp = ($urandom_range(0, 13) == 0);
            step(ss, cl, lp);
            checks++;
            if ({disp, running, lap_active, overflow} !==
                {exp_disp(), (m_state == M_RUN), (m_lap != 0), (m_ovf != 0)}) begin
                errors++;
                $display("FAIL random_cycle%0d: disp/run/lap/ovf=%h/%b/%b/%b required %h/%b/%b/%b",
                         i, disp, running, lap_active, overflow,
                         exp_disp(), (m_state == M_RUN), (m_lap != 0), (m_ovf != 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_wrap();
        test_lap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
